// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module : ntt_pkg
// Brief  : Shared NTT constants: moduli, multiplier latencies, Barrett factor.
// Rev    : 1.0
// ============================================================================
package ntt_pkg;

  localparam int COEF_W  = 30;
  localparam int MU_W    = 34;
  localparam int NUM_MOD = 3;

  typedef logic [COEF_W-1:0] coef_t;

  localparam coef_t Q_TABLE [NUM_MOD] = '{
    30'd998244353,
    30'd469762049,
    30'd167772161
  };

  localparam int MUL_LAT_TABLE [NUM_MOD] = '{8, 8, 8};

  // floor(2^(2*COEF_W) / q): keeps the Barrett quotient estimate at most one low.
  function automatic logic [MU_W-1:0] barrett_mu(input coef_t q);
    logic [63:0] num;
    num = 64'd1 << (2 * COEF_W);
    return MU_W'(num / 64'(q));
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module : delay_line
// Brief  : DEPTH-stage register chain with synchronous active-low clear.
// Rev    : 1.0
// ============================================================================
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout_o = din_i;
    end else begin : g_regs
      logic [WIDTH-1:0] pipe_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= din_i;
          for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign dout_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/modular_adder.sv
`default_nettype none
// ============================================================================
// Module : modular_adder
// Brief  : Registered s = (a + b) mod q for a, b in [0, q-1].
// Rev    : 1.0
// ============================================================================
module modular_adder
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0
) (
  input  logic              clk,
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  output logic [COEF_W-1:0] s_o
);

  localparam coef_t Q   = Q_TABLE[MOD_INDEX];
  localparam int    S_W = COEF_W + 1;

  logic [S_W-1:0]    sum_d;
  logic [COEF_W-1:0] s_d, s_q;

  always_comb begin
    sum_d = S_W'(a_i) + S_W'(b_i);
    s_d   = (sum_d >= S_W'(Q)) ? COEF_W'(sum_d - S_W'(Q)) : COEF_W'(sum_d);
  end

  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign s_o = s_q;

endmodule
`default_nettype wire

// File: rtl/modular_multiplier.sv
`default_nettype none
// ============================================================================
// Module : modular_multiplier
// Brief  : Pipelined Barrett modular multiply p = a*b mod q, LAT cycles (>= 4).
// Rev    : 1.0
// ============================================================================
module modular_multiplier
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0,
  parameter int LAT       = 8
) (
  input  logic              clk,
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  output logic [COEF_W-1:0] p_o
);

  localparam coef_t           Q        = Q_TABLE[MOD_INDEX];
  localparam logic [MU_W-1:0] MU       = barrett_mu(Q);
  localparam int              CORE_LAT = 4;
  localparam int              PAD      = LAT - CORE_LAT;
  localparam int              X_W      = 2 * COEF_W;
  localparam int              T_W      = X_W + MU_W;
  localparam int              R_W      = COEF_W + 1;

  logic [X_W-1:0]    x1_d, x1_q, x2_q;
  logic [T_W-1:0]    t_d;
  logic [COEF_W-1:0] qhat_d, qhat_q;
  logic [R_W-1:0]    r_d, r_q;
  logic [COEF_W-1:0] p_d, p_q;

  // qhat <= floor(x/q) and qhat >= floor(x/q)-1, so r lies in [0, 2q).
  always_comb begin
    x1_d   = X_W'(a_i) * X_W'(b_i);
    t_d    = T_W'(x1_q) * T_W'(MU);
    qhat_d = COEF_W'(t_d >> X_W);
    r_d    = R_W'(x2_q - X_W'(qhat_q) * X_W'(Q));
    p_d    = (r_q >= R_W'(Q)) ? COEF_W'(r_q - R_W'(Q)) : COEF_W'(r_q);
  end

  always_ff @(posedge clk) begin
    x1_q   <= x1_d;
    x2_q   <= x1_q;
    qhat_q <= qhat_d;
    r_q    <= r_d;
    p_q    <= p_d;
  end

  delay_line #(
    .WIDTH (COEF_W),
    .DEPTH (PAD)
  ) u_pad (
    .clk    (clk),
    .rst_n  (1'b1),
    .din_i  (p_q),
    .dout_o (p_o)
  );

endmodule
`default_nettype wire

// File: rtl/modular_subtractor.sv
`default_nettype none
// ============================================================================
// Module : modular_subtractor
// Brief  : Registered d = (a - b) mod q for a, b in [0, q-1].
// Rev    : 1.0
// ============================================================================
module modular_subtractor
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0
) (
  input  logic              clk,
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  output logic [COEF_W-1:0] d_o
);

  localparam coef_t Q   = Q_TABLE[MOD_INDEX];
  localparam int    S_W = COEF_W + 1;

  logic [COEF_W-1:0] d_d, d_q;

  always_comb begin
    if (a_i >= b_i) begin
      d_d = a_i - b_i;
    end else begin
      d_d = COEF_W'(S_W'(a_i) + S_W'(Q) - S_W'(b_i));
    end
  end

  always_ff @(posedge clk) begin
    d_q <= d_d;
  end

  assign d_o = d_q;

endmodule
`default_nettype wire

// File: rtl/ct_butterfly.sv
`default_nettype none
// ============================================================================
// Module : ct_butterfly
// Brief  : Pipelined Cooley-Tukey NTT butterfly a=(A+wB) mod q, b=(A-wB) mod q.
// Rev    : 1.0
// ============================================================================
module ct_butterfly
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0,
  parameter int MUL_LAT   = 8,
  parameter int TAG_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [COEF_W-1:0] A,
  input  logic [COEF_W-1:0] B,
  input  logic [COEF_W-1:0] w,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              bypass,
  output logic              out_valid,
  output logic [COEF_W-1:0] a,
  output logic [COEF_W-1:0] b,
  output logic [TAG_W-1:0]  out_tag
);

  logic [COEF_W-1:0] a_pipe, b_pipe, prod, sum, diff;
  logic              valid_pipe, bypass_pipe;
  logic [TAG_W-1:0]  tag_pipe;

  logic              valid_q, bypass_q;
  logic [TAG_W-1:0]  tag_q;
  logic [COEF_W-1:0] a_d2_q, b_d2_q;

  modular_multiplier #(
    .MOD_INDEX (MOD_INDEX),
    .LAT       (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .a_i (B),
    .b_i (w),
    .p_o (prod)
  );

  delay_line #(.WIDTH(COEF_W), .DEPTH(MUL_LAT)) u_a_pipe (
    .clk (clk), .rst_n (rst_n), .din_i (A), .dout_o (a_pipe)
  );

  delay_line #(.WIDTH(COEF_W), .DEPTH(MUL_LAT)) u_b_pipe (
    .clk (clk), .rst_n (rst_n), .din_i (B), .dout_o (b_pipe)
  );

  delay_line #(.WIDTH(1), .DEPTH(MUL_LAT)) u_valid_pipe (
    .clk (clk), .rst_n (rst_n), .din_i (in_valid), .dout_o (valid_pipe)
  );

  delay_line #(.WIDTH(TAG_W), .DEPTH(MUL_LAT)) u_tag_pipe (
    .clk (clk), .rst_n (rst_n), .din_i (in_tag), .dout_o (tag_pipe)
  );

  delay_line #(.WIDTH(1), .DEPTH(MUL_LAT)) u_bypass_pipe (
    .clk (clk), .rst_n (rst_n), .din_i (bypass), .dout_o (bypass_pipe)
  );

  modular_adder #(.MOD_INDEX(MOD_INDEX)) u_add (
    .clk (clk), .a_i (a_pipe), .b_i (prod), .s_o (sum)
  );

  modular_subtractor #(.MOD_INDEX(MOD_INDEX)) u_sub (
    .clk (clk), .a_i (a_pipe), .b_i (prod), .d_o (diff)
  );

  // Sideband and bypass data take the extra stage the adder/subtractor register adds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bypass_q <= 1'b0;
      tag_q    <= '0;
      a_d2_q   <= '0;
      b_d2_q   <= '0;
    end else begin
      valid_q  <= valid_pipe;
      bypass_q <= bypass_pipe;
      tag_q    <= tag_pipe;
      a_d2_q   <= a_pipe;
      b_d2_q   <= b_pipe;
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_tag   = tag_q;
    a         = bypass_q ? a_d2_q : sum;
    b         = bypass_q ? b_d2_q : diff;
  end

endmodule
`default_nettype wire

// File: tb/tb_ct_butterfly.sv
`default_nettype none
// ============================================================================
// Module : tb_ct_butterfly
// Brief  : Scoreboard bench for ct_butterfly (MOD_INDEX 0, q = 998244353).
// Rev    : 1.0
// ============================================================================
module tb_ct_butterfly;

  localparam int              MUL_LAT = 8;
  localparam int              L       = MUL_LAT + 1;
  localparam int              TAG_W   = 10;
  localparam logic [29:0]     Q       = 30'd998244353;
  localparam longint unsigned QL      = 64'd998244353;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              in_valid = 1'b0;
  logic [29:0]       A        = '0;
  logic [29:0]       B        = '0;
  logic [29:0]       w        = '0;
  logic [TAG_W-1:0]  in_tag   = '0;
  logic              bypass   = 1'b0;
  logic              out_valid;
  logic [29:0]       a;
  logic [29:0]       b;
  logic [TAG_W-1:0]  out_tag;

  ct_butterfly #(
    .MOD_INDEX (0),
    .MUL_LAT   (MUL_LAT),
    .TAG_W     (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .w         (w),
    .in_tag    (in_tag),
    .bypass    (bypass),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0]      ea;
    logic [29:0]      eb;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t sbq[$];
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   valid_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid must match the oldest outstanding butterfly, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      valid_seen++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cyc=%0d got tag=%0d a=%0d b=%0d, want no output",
                 cyc, out_tag, a, b);
      end else begin
        e = sbq.pop_front();
        if (a !== e.ea || b !== e.eb || out_tag !== e.tag || cyc != e.due) begin
          errors++;
          $display("FAIL butterfly tag=%0d: got a=%0d b=%0d tag=%0d cyc=%0d, want a=%0d b=%0d tag=%0d cyc=%0d",
                   e.tag, a, b, out_tag, cyc, e.ea, e.eb, e.tag, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [29:0] ia, input logic [29:0] ib,
                       input logic [29:0] iw, input logic [TAG_W-1:0] t, input logic byp);
    @(posedge clk);
    #1;
    in_valid = v;
    A        = ia;
    B        = ib;
    w        = iw;
    in_tag   = t;
    bypass   = byp;
  endtask

  task automatic issue(input logic [29:0] ia, input logic [29:0] ib, input logic [29:0] iw,
                       input logic [TAG_W-1:0] t, input logic byp,
                       input logic [29:0] ea, input logic [29:0] eb);
    drive(1'b1, ia, ib, iw, t, byp);
    sbq.push_back('{ea, eb, t, cyc + L});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 30'($urandom), 30'($urandom), 30'($urandom), TAG_W'($urandom), 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  function automatic void model(input logic [29:0] ia, input logic [29:0] ib,
                                input logic [29:0] iw,
                                output logic [29:0] ea, output logic [29:0] eb);
    longint unsigned x, y, p, s;
    x  = 64'(ib);
    y  = 64'(iw);
    p  = (x * y) % QL;
    s  = 64'(ia);
    ea = 30'((s + p) % QL);
    eb = 30'((s + QL - p) % QL);
  endfunction

  initial begin
    logic [29:0] ra, rb, rw, ea, eb;
    int          vs;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);

    // Directed vectors, expected values worked by hand.
    issue(30'd5, 30'd3, 30'd2, 10'd1, 1'b0, 30'd11, Q - 30'd1);
    issue(Q - 30'd1, 30'd1, 30'd1, 10'd2, 1'b0, 30'd0, Q - 30'd2);
    issue(30'd0, 30'd1, Q - 30'd1, 10'd3, 1'b0, Q - 30'd1, 30'd1);
    issue(Q - 30'd1, Q - 30'd1, Q - 30'd1, 10'd4, 1'b0, 30'd0, Q - 30'd2);
    issue(30'd123, 30'd456, 30'd789, 10'd5, 1'b1, 30'd123, 30'd456);
    issue(30'd7, 30'd9, 30'd10, 10'd6, 1'b0, 30'd97, Q - 30'd83);
    idle(2);
    issue(30'd1000, 30'd0, 30'd5, 10'd7, 1'b0, 30'd1000, 30'd1000);
    idle(1);
    wait_drain(40);

    // Streaming with gap pattern; tags 0..63.
    for (int i = 0; i < 64; i++) begin
      ra = 30'($urandom_range(32'(QL - 1), 0));
      rb = 30'($urandom_range(32'(QL - 1), 0));
      rw = 30'($urandom_range(32'(QL - 1), 0));
      model(ra, rb, rw, ea, eb);
      issue(ra, rb, rw, TAG_W'(i), 1'b0, ea, eb);
      if (i % 5 == 3)  idle(1);
      if (i % 11 == 7) idle(3);
    end
    idle(1);
    wait_drain(40);

    // Reset mid-stream: five butterflies in flight are discarded.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 30'(100 + i), 30'(200 + i), 30'd3, TAG_W'(40 + i), 1'b0);
    end
    idle(3);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_tag   = 10'd77;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_tag   = '0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", 64'(out_valid), 64'd0);
      check("post_reset_out_tag", 64'(out_tag), 64'd0);
    end
    issue(30'd11, 30'd2, 30'd5, 10'd99, 1'b0, 30'd21, 30'd1);
    idle(1);
    wait_drain(40);

    // Idle: no valid for 100 cycles after reset.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    vs = valid_seen;
    idle(100);
    @(negedge clk);
    check("idle_out_valid_count", 64'(valid_seen - vs), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cyc=%0d want completion", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
